mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - MAR/MDR-style front end for the 512x32 RAM: accepts one load/store request at a time from the
//   control unit, latches address/data, drives the RAM read/write strobes, captures read data.
// - Sits directly upstream of the RAM; all RAM inputs come from this block's registers.
// - Serialises accesses and rejects out-of-range addresses before they reach the RAM.
// PARAMETERS
// - ADDR_W     9   RAM address width (RAM depth = 2**ADDR_W words)
// - DATA_W     32  data word width
// - ADDR_CHECK 1   1: req_addr[31:ADDR_W] != 0 is an error; 0: upper bits ignored
// PORTS
// - clock       in   1       single clock, all state on rising edge
// - clear_n     in   1       reset, asynchronous, active-low
// - req_valid   in   1       request present
// - req_ready   out  1       block can accept (high only in IDLE)
// - req_write   in   1       1 = store, 0 = load
// - req_addr    in   32      word address from bus (low ADDR_W bits used)
// - req_wdata   in   DATA_W  store data
// - resp_valid  out  1       response present, held until taken
// - resp_ready  in   1       consumer takes response
// - resp_rdata  out  DATA_W  load data (0 for stores and errors)
// - resp_err    out  1       address out of range, no RAM access made
// - ram_read    out  1       RAM read strobe
// - ram_write   out  1       RAM write strobe
// - ram_addr    out  ADDR_W  RAM address (MAR)
// - ram_data    out  DATA_W  RAM write data (MDR)
// - ram_q       in   DATA_W  RAM data_output (valid one edge after ram_read sampled)
// BEHAVIOUR
// - All outputs registered. Reset: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0,
//   ram_read=0, ram_write=0, ram_addr=0, ram_data=0.
// - Accept = req_valid & req_ready at a rising edge; latch MAR<=req_addr[ADDR_W-1:0],
//   MDR<=req_wdata, op<=req_write. No other input sampled outside IDLE.
// - FSM: IDLE, ACCESS, RDWAIT, RESP.
//   IDLE  : accept & addr ok -> ACCESS, ram_read=~op / ram_write=op for exactly one cycle.
//           accept & addr bad (ADDR_CHECK=1) -> RESP, resp_err=1, resp_rdata=0, no strobe.
//   ACCESS: strobes low next edge; load -> RDWAIT; store -> RESP (resp_rdata=0).
//   RDWAIT: capture ram_q into resp_rdata -> RESP.
//   RESP  : resp_valid=1; resp_valid & resp_ready -> IDLE (resp_valid=0, resp_err=0, req_ready=1).
// - Never ram_read and ram_write together; strobe width exactly 1 cycle.
// - Latency, accept edge = E0, resp_ready held high: store resp_valid high in cycle after E1
//   (2 cycles); load after E2 (3 cycles); error after E0 (1 cycle). Back-to-back accept
//   possible the cycle after the response is taken (req_ready rises with resp handshake edge).
// - resp_rdata/resp_err stable while resp_valid=1 and resp_ready=0 (indefinite stall allowed).
// - ram_addr/ram_data hold last latched value between accesses.
// - clear_n low mid-operation: immediate return to reset values, strobes drop without clock;
//   a write whose strobe was sampled by RAM before reset stays committed; no response issued.
// - Address wrap: with ADDR_CHECK=0, address 0x200 maps to RAM word 0.
// TESTING
// - Store 0xDEADBEEF @0x1FF, then load 0x1FF -> ram_write one cycle, resp after 2 cycles;
//   load resp_rdata=0xDEADBEEF after 3 cycles, resp_err=0.
// - Load @0x200, ADDR_CHECK=1 -> resp_err=1, resp_rdata=0, ram_read/ram_write never asserted.
// - Load with resp_ready low 5 cycles -> resp_valid, resp_rdata stable; req_ready=0 throughout;
//   second req_valid ignored until handshake.
// - Back-to-back stores @0,@1 (0x11,0x22) with req_valid held -> second accept on handshake edge;
//   loads return 0x11, 0x22.
// - clear_n pulsed low during RDWAIT -> all outputs at reset values asynchronously; next load of
//   unwritten address returns 0.
// - ADDR_CHECK=0, store 0x5 @0x203 -> load @0x003 returns 0x5.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MAR/MDR front end for a 2**ADDR_W x DATA_W RAM: serialises one load/store at a time,
// drives single-cycle RAM strobes from its own registers and rejects out-of-range addresses.
module mem_access_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter bit ADDR_CHECK = 1'b1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is high only in IDLE; resp_valid and its payload hold until resp_ready is seen.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              ram_read_q;
  logic              ram_write_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              op_q;
  logic              addr_bad;

  assign addr_bad = ADDR_CHECK && ((req_addr >> ADDR_W) != 32'd0);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      mar_q        <= '0;
      mdr_q        <= '0;
      op_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mar_q       <= req_addr[ADDR_W-1:0];
            mdr_q       <= req_wdata;
            op_q        <= req_write;
            req_ready_q <= 1'b0;
            if (addr_bad) begin
              // Rejected request goes straight to the response; the RAM never sees a strobe.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= ACCESS;
              ram_read_q  <= ~req_write;
              ram_write_q <= req_write;
            end
          end
        end
        ACCESS: begin
          ram_read_q  <= 1'b0;
          ram_write_q <= 1'b0;
          if (op_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end else begin
            state_q <= RDWAIT;
          end
        end
        RDWAIT: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= ram_q;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_read   = ram_read_q;
  assign ram_write  = ram_write_q;
  assign ram_addr   = mar_q;
  assign ram_data   = mdr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (address check on / off), each with its own RAM,
// directed scenarios plus a randomized run against a word-level reference memory.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;

  logic              clock;
  logic              clear_n;
  logic              req_valid;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_ready;
  logic              sel;

  logic              req_ready_a  [2];
  logic              resp_valid_a [2];
  logic              resp_err_a   [2];
  logic              ram_read_a   [2];
  logic              ram_write_a  [2];
  logic [DATA_W-1:0] resp_rdata_a [2];
  logic [DATA_W-1:0] ram_data_a   [2];
  logic [DATA_W-1:0] ram_q_a      [2];
  logic [ADDR_W-1:0] ram_addr_a   [2];
  logic [1:0]        dbg_a        [2];
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic              req_valid_c, req_valid_n;
  logic              req_ready, resp_valid, resp_err, ram_read, ram_write;
  logic [DATA_W-1:0] resp_rdata, ram_data;
  logic [ADDR_W-1:0] ram_addr;

  int checks;
  int failures;
  int last_lat, last_rd, last_wr, last_wait;
  logic [DATA_W-1:0] last_rdata;
  logic              last_err;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic              err_q [$];
  int                lat_q [$];
  int                rd_q  [$];
  int                wr_q  [$];

  assign req_valid_c = req_valid && (sel == 1'b0);
  assign req_valid_n = req_valid && (sel == 1'b1);
  assign req_ready   = sel ? req_ready_a[1]  : req_ready_a[0];
  assign resp_valid  = sel ? resp_valid_a[1] : resp_valid_a[0];
  assign resp_err    = sel ? resp_err_a[1]   : resp_err_a[0];
  assign resp_rdata  = sel ? resp_rdata_a[1] : resp_rdata_a[0];
  assign ram_read    = sel ? ram_read_a[1]   : ram_read_a[0];
  assign ram_write   = sel ? ram_write_a[1]  : ram_write_a[0];
  assign ram_addr    = sel ? ram_addr_a[1]   : ram_addr_a[0];
  assign ram_data    = sel ? ram_data_a[1]   : ram_data_a[0];

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_CHECK(1'b1)) u_chk (
    .clock(clock), .clear_n(clear_n),
    .req_valid(req_valid_c), .req_ready(req_ready_a[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a[0]),
    .resp_err(resp_err_a[0]), .ram_read(ram_read_a[0]), .ram_write(ram_write_a[0]),
    .ram_addr(ram_addr_a[0]), .ram_data(ram_data_a[0]), .ram_q(ram_q_a[0]),
    .dbg_state(dbg_a[0])
  );

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_CHECK(1'b0)) u_nochk (
    .clock(clock), .clear_n(clear_n),
    .req_valid(req_valid_n), .req_ready(req_ready_a[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a[1]),
    .resp_err(resp_err_a[1]), .ram_read(ram_read_a[1]), .ram_write(ram_write_a[1]),
    .ram_addr(ram_addr_a[1]), .ram_data(ram_data_a[1]), .ram_q(ram_q_a[1]),
    .dbg_state(dbg_a[1])
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- RAMs behind each instance (contents survive clear_n) ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    ram_q_a[0] = '0;
    ram_q_a[1] = '0;
    forever begin
      @(posedge clock);
      if (ram_write_a[0]) mem0[ram_addr_a[0]] <= ram_data_a[0];
      if (ram_read_a[0])  ram_q_a[0] <= mem0[ram_addr_a[0]];
      if (ram_write_a[1]) mem1[ram_addr_a[1]] <= ram_data_a[1];
      if (ram_read_a[1])  ram_q_a[1] <= mem1[ram_addr_a[1]];
    end
  end

  // ---------------- strobe protocol monitor ----------------
  logic prev_str [2];
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!clear_n) begin
        prev_str[k] <= 1'b0;
      end else begin
        if (ram_read_a[k] || ram_write_a[k]) begin
          checks++;
          if ((ram_read_a[k] && ram_write_a[k]) || prev_str[k]) begin
            failures++;
            $display("FAIL strobe_protocol dut=%0d got read=%0b write=%0b prev=%0b exp one strobe for one cycle",
                     k, ram_read_a[k], ram_write_a[k], prev_str[k]);
          end
        end
        prev_str[k] <= ram_read_a[k] || ram_write_a[k];
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model(input logic w, input logic [31:0] a, input logic [DATA_W-1:0] d);
    int idx;
    if (a >= DEPTH) begin
      exp_q.push_back('0); err_q.push_back(1'b1); lat_q.push_back(1);
      rd_q.push_back(0); wr_q.push_back(0);
    end else begin
      idx = a % DEPTH;
      err_q.push_back(1'b0);
      if (w) begin
        ref_mem[idx] = d;
        exp_q.push_back('0); lat_q.push_back(2); rd_q.push_back(0); wr_q.push_back(1);
      end else begin
        exp_q.push_back(ref_mem[idx]); lat_q.push_back(3); rd_q.push_back(1); wr_q.push_back(0);
      end
    end
  endtask

  // ---------------- drivers (start and end on a falling edge) ----------------
  task automatic send(input logic w, input logic [31:0] a, input logic [DATA_W-1:0] d, input logic rr);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = rr;
    last_wait = 0;
    while (!req_ready && last_wait < 50) begin
      @(negedge clock);
      last_wait++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout got req_ready=0 exp=1");
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    last_lat = 1; last_rd = 0; last_wr = 0;
    forever begin
      if (ram_read)  last_rd++;
      if (ram_write) last_wr++;
      if (resp_valid || last_lat >= 20) break;
      @(negedge clock);
      last_lat++;
    end
    last_rdata = resp_rdata;
    last_err   = resp_err;
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%0b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%0b exp=0", resp_err); end
    checks++; if (resp_rdata !== '0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if ({ram_read, ram_write} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {ram_read, ram_write}); end
    checks++; if (ram_addr !== '0) begin failures++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (ram_data !== '0) begin failures++; $display("FAIL rst_ram_data got=%h exp=0", ram_data); end
    clear_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_store_load();
    sel = 1'b0;
    send(1'b1, 32'h1FF, 32'hDEADBEEF, 1'b1);
    checks++; if (last_lat !== 2) begin failures++; $display("FAIL st_latency got=%0d exp=2", last_lat); end
    checks++; if (last_wr !== 1 || last_rd !== 0) begin failures++; $display("FAIL st_strobes got wr=%0d rd=%0d exp wr=1 rd=0", last_wr, last_rd); end
    checks++; if (last_err !== 1'b0 || last_rdata !== '0) begin failures++; $display("FAIL st_resp got err=%0b rdata=%h exp err=0 rdata=0", last_err, last_rdata); end
    take_resp();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL st_handshake got valid=%0b ready=%0b exp 0 1", resp_valid, req_ready); end
    checks++; if (ram_addr !== 9'h1FF || ram_data !== 32'hDEADBEEF) begin failures++; $display("FAIL st_hold got addr=%h data=%h exp 1ff deadbeef", ram_addr, ram_data); end
    send(1'b0, 32'h1FF, 32'h0, 1'b1);
    checks++; if (last_lat !== 3) begin failures++; $display("FAIL ld_latency got=%0d exp=3", last_lat); end
    checks++; if (last_rd !== 1 || last_wr !== 0) begin failures++; $display("FAIL ld_strobes got rd=%0d wr=%0d exp rd=1 wr=0", last_rd, last_wr); end
    checks++; if (last_rdata !== 32'hDEADBEEF || last_err !== 1'b0) begin failures++; $display("FAIL ld_resp got rdata=%h err=%0b exp deadbeef 0", last_rdata, last_err); end
    take_resp();
  endtask

  task automatic test_addr_error();
    sel = 1'b0;
    send(1'b0, 32'h200, 32'h0, 1'b1);
    checks++; if (last_lat !== 1) begin failures++; $display("FAIL err_latency got=%0d exp=1", last_lat); end
    checks++; if (last_err !== 1'b1 || last_rdata !== '0) begin failures++; $display("FAIL err_resp got err=%0b rdata=%h exp 1 0", last_err, last_rdata); end
    checks++; if (last_rd !== 0 || last_wr !== 0) begin failures++; $display("FAIL err_strobes got rd=%0d wr=%0d exp 0 0", last_rd, last_wr); end
    take_resp();
    checks++; if (resp_err !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL err_clear got err=%0b ready=%0b exp 0 1", resp_err, req_ready); end
  endtask

  task automatic test_stall();
    sel = 1'b0;
    send(1'b0, 32'h1FF, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1FF; req_wdata = 32'h0BAD0BAD;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || ram_write !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got valid=%0b rdata=%h ready=%0b wr=%0b exp 1 deadbeef 0 0",
                 i, resp_valid, resp_rdata, req_ready, ram_write);
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    take_resp();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%0b exp=0", resp_valid); end
    send(1'b0, 32'h1FF, 32'h0, 1'b1);
    checks++; if (last_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_ignored got=%h exp=deadbeef", last_rdata); end
    take_resp();
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    send(1'b1, 32'h0, 32'h11, 1'b1);
    send(1'b1, 32'h1, 32'h22, 1'b1);
    checks++; if (last_wait !== 1) begin failures++; $display("FAIL b2b_accept_wait got=%0d exp=1", last_wait); end
    checks++; if (last_lat !== 2 || last_wr !== 1) begin failures++; $display("FAIL b2b_store got lat=%0d wr=%0d exp 2 1", last_lat, last_wr); end
    send(1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (last_rdata !== 32'h11) begin failures++; $display("FAIL b2b_load0 got=%h exp=11", last_rdata); end
    send(1'b0, 32'h1, 32'h0, 1'b1);
    checks++; if (last_wait !== 1 || last_rdata !== 32'h22) begin failures++; $display("FAIL b2b_load1 got wait=%0d rdata=%h exp 1 22", last_wait, last_rdata); end
    take_resp();
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    for (int s = 0; s < 3; s++) begin
      req_valid = 1'b1; req_write = (s == 2); req_addr = (s == 2) ? 32'h151 : 32'h150;
      req_wdata = 32'h77; resp_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      if (s == 0) begin
        checks++; if (ram_read !== 1'b1) begin failures++; $display("FAIL rmid_strobe_before got=%0b exp=1", ram_read); end
      end else begin
        @(posedge clock);
        @(negedge clock);
      end
      #2 clear_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_err, ram_read, ram_write} !== 5'b10000 ||
          resp_rdata !== '0 || ram_addr !== '0 || ram_data !== '0) begin
        failures++;
        $display("FAIL rmid_async scen=%0d got rdy=%0b v=%0b e=%0b rd=%0b wr=%0b rdata=%h addr=%h data=%h exp 1 0 0 0 0 0 0 0",
                 s, req_ready, resp_valid, resp_err, ram_read, ram_write, resp_rdata, ram_addr, ram_data);
      end
      @(negedge clock);
      clear_n = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rmid_no_resp scen=%0d got v=%0b rdy=%0b exp 0 1", s, resp_valid, req_ready); end
    end
    send(1'b0, 32'h150, 32'h0, 1'b1);
    checks++; if (last_rdata !== '0 || last_err !== 1'b0) begin failures++; $display("FAIL rmid_unwritten got rdata=%h err=%0b exp 0 0", last_rdata, last_err); end
    send(1'b0, 32'h151, 32'h0, 1'b1);
    checks++; if (last_rdata !== 32'h77) begin failures++; $display("FAIL rmid_committed got=%h exp=77", last_rdata); end
    take_resp();
  endtask

  task automatic test_no_check();
    sel = 1'b1;
    send(1'b1, 32'h203, 32'h5, 1'b1);
    checks++; if (last_err !== 1'b0 || last_lat !== 2 || last_wr !== 1) begin failures++; $display("FAIL nochk_store got err=%0b lat=%0d wr=%0d exp 0 2 1", last_err, last_lat, last_wr); end
    checks++; if (ram_addr !== 9'h003) begin failures++; $display("FAIL nochk_wrap_addr got=%h exp=003", ram_addr); end
    send(1'b0, 32'h003, 32'h0, 1'b1);
    checks++; if (last_rdata !== 32'h5 || last_err !== 1'b0) begin failures++; $display("FAIL nochk_load got rdata=%h err=%0b exp 5 0", last_rdata, last_err); end
    take_resp();
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic              w;
    logic [31:0]       a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_d;
    logic              exp_e;
    int                exp_lat, exp_rd, exp_wr, stall;
    sel = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem0[i];
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(512, 32'h0001_FFFF) : 32'h80 + $urandom_range(0, 15);
      d = $urandom;
      stall = $urandom_range(0, 3);
      model(w, a, d);
      send(w, a, d, stall == 0);
      exp_d = exp_q.pop_front(); exp_e = err_q.pop_front(); exp_lat = lat_q.pop_front();
      exp_rd = rd_q.pop_front(); exp_wr = wr_q.pop_front();
      checks++; if (last_rdata !== exp_d) begin failures++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, last_rdata, exp_d); end
      checks++; if (last_err !== exp_e) begin failures++; $display("FAIL rnd_err i=%0d got=%0b exp=%0b", i, last_err, exp_e); end
      checks++; if (last_lat !== exp_lat) begin failures++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, last_lat, exp_lat); end
      checks++; if (last_rd !== exp_rd || last_wr !== exp_wr) begin failures++; $display("FAIL rnd_strobes i=%0d got rd=%0d wr=%0d exp rd=%0d wr=%0d", i, last_rd, last_wr, exp_rd, exp_wr); end
      repeat (stall) begin
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== exp_d || resp_err !== exp_e) begin
          failures++;
          $display("FAIL rnd_stall i=%0d got v=%0b rdata=%h err=%0b exp 1 %h %0b", i, resp_valid, resp_rdata, resp_err, exp_d, exp_e);
        end
      end
      take_resp();
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rnd_handshake i=%0d got v=%0b rdy=%0b exp 0 1", i, resp_valid, req_ready); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; failures = 0;
    clear_n = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    test_reset();
    test_store_load();
    test_addr_error();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_no_check();
    test_random();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
